fini_error_handler: RTL and testbench

Sequential stage directly downstream of the FINI multiply-and-detect stage (K=5, 6-bit repetition codewords). It accepts each encoded product together with the upstream consistency flag and re-checks the codeword. Faulty words are infected, i.e. replaced by the all-zero codeword and tagged. Faults are counted, and the block locks into a permanent alarm state once a threshold is reached. Between the two it buffers results in a 2-entry FIFO with valid/ready handshakes on both sides.

---
 rtl/fini_error_handler.sv | 98 +++++++++
 tb/tb_fini_error_handler.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fini_error_handler.sv
// fini_error_handler: re-checks FINI codewords, infects faults, counts them and locks on threshold, 2-entry output FIFO.
// Optional counter/infection feature enabled by defining FINI_ERR_COUNT_EN.
module fini_error_handler #(
    parameter int K         = 5,
    parameter int THRESHOLD = 3,
    parameter int CNT_W     = 4
) (
    input  logic             port_clk,
    input  logic             port_rst,
    input  logic [K:0]       port_c_in,
    input  logic             port_flag_in,
    input  logic             port_in_valid,
    output logic             port_in_ready,
    output logic [K:0]       port_out_c,
    output logic             port_out_fault,
    output logic             port_out_valid,
    input  logic             port_out_ready,
    output logic             port_alarm,
    output logic [CNT_W-1:0] port_err_count
);
    typedef enum logic {RUN, LOCK} state_t;
    state_t r_state, w_state_next;
    logic [K:0] r_mem_c [2];
    logic [1:0] r_mem_f;
    logic       r_rd, r_wr;
    logic [1:0] r_count_fifo;
    logic       w_accept, w_ok, w_faulty, w_run, w_lock_now, w_push, w_pop;

    assign w_run         = r_state == RUN;
    assign port_in_ready = !port_rst & (!w_run | r_count_fifo != 2'd2);
    assign w_accept      = port_in_valid & port_in_ready;
    assign w_ok          = (&port_c_in) | ~(|port_c_in);
    assign w_faulty      = !w_ok | !port_flag_in;
    assign w_push        = w_accept & w_run & !w_lock_now;
    assign w_pop         = port_out_valid & port_out_ready;
    assign port_out_c     = r_mem_c[r_rd];
    assign port_out_fault = r_mem_f[r_rd];

`ifdef FINI_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err, w_err_inc;
    logic             w_fault_acc;
    assign w_err_inc   = (&r_err) ? r_err : r_err + CNT_W'(1);
    assign w_fault_acc = w_accept & w_run & w_faulty;
    assign w_lock_now  = w_fault_acc & (w_err_inc >= CNT_W'(THRESHOLD));
    assign port_err_count = r_err;

    always_ff @(posedge port_clk) begin
        if (port_rst)
            r_err <= '0;
        else if (w_fault_acc)
            r_err <= w_err_inc;
    end
`else
    // Without the counter any fault locks immediately; THRESHOLD only sizes nothing here.
    assign w_lock_now     = w_accept & w_run & w_faulty;
    assign port_err_count = CNT_W'(THRESHOLD) & {CNT_W{1'b0}};
`endif

    always_ff @(posedge port_clk) begin
        if (port_rst)
            r_state <= RUN;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        port_alarm     = !w_run;
        port_out_valid = w_run & (r_count_fifo != 2'd0);
        if (w_lock_now)
            w_state_next = LOCK;
    end

    // Entering LOCK flushes the FIFO on the same edge as the locking fault.
    always_ff @(posedge port_clk) begin
        if (port_rst) begin
            r_mem_c[0]   <= '0;
            r_mem_c[1]   <= '0;
            r_mem_f      <= '0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_count_fifo <= 2'd0;
        end else if (w_lock_now) begin
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_count_fifo <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_c[r_wr] <= w_faulty ? '0 : port_c_in;
                r_mem_f[r_wr] <= w_faulty;
                r_wr          <= !r_wr;
            end
            if (w_pop)
                r_rd <= !r_rd;
            r_count_fifo <= r_count_fifo + {1'b0, w_push} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_fini_error_handler.sv
// tb_fini_error_handler: directed self-checking bench for fini_error_handler (K=5, THRESHOLD=3, CNT_W=4).
module tb_fini_error_handler;
    logic       port_clk = 1'b0;
    logic       port_rst;
    logic [5:0] port_c_in;
    logic       port_flag_in;
    logic       port_in_valid;
    logic       port_in_ready;
    logic [5:0] port_out_c;
    logic       port_out_fault;
    logic       port_out_valid;
    logic       port_out_ready;
    logic       port_alarm;
    logic [3:0] port_err_count;
    int tests = 0;
    int fails = 0;

    fini_error_handler #(.K(5), .THRESHOLD(3), .CNT_W(4)) dut (
        .port_clk(port_clk), .port_rst(port_rst), .port_c_in(port_c_in),
        .port_flag_in(port_flag_in), .port_in_valid(port_in_valid),
        .port_in_ready(port_in_ready), .port_out_c(port_out_c),
        .port_out_fault(port_out_fault), .port_out_valid(port_out_valid),
        .port_out_ready(port_out_ready), .port_alarm(port_alarm),
        .port_err_count(port_err_count)
    );

    always #5 port_clk = ~port_clk;

    task automatic step();
        @(posedge port_clk);
        #1;
    endtask

    task automatic test_reset();
        port_rst = 1'b1; port_in_valid = 1'b0; port_c_in = '0; port_flag_in = 1'b1; port_out_ready = 1'b1;
        step();
        step();
        tests++; if (port_in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", port_in_ready); end
        tests++; if (port_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", port_out_valid); end
        tests++; if (port_alarm !== 1'b0 || port_err_count !== 4'd0) begin fails++; $display("FAIL reset_alarm_count got=%b/%0d exp=0/0", port_alarm, port_err_count); end
        tests++; if (port_out_c !== 6'h00 || port_out_fault !== 1'b0) begin fails++; $display("FAIL reset_out_c got=%h/%b exp=00/0", port_out_c, port_out_fault); end
        port_rst = 1'b0;
        #1;
        tests++; if (port_in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", port_in_ready); end
    endtask

    task automatic test_basic();
        port_out_ready = 1'b1;
        port_c_in = 6'h3f; port_flag_in = 1'b1; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h3f || port_out_fault !== 1'b0) begin fails++; $display("FAIL basic_w0 got=%b/%h/%b exp=1/3f/0", port_out_valid, port_out_c, port_out_fault); end
        port_c_in = 6'h00; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h00 || port_out_fault !== 1'b0) begin fails++; $display("FAIL basic_w1 got=%b/%h/%b exp=1/00/0", port_out_valid, port_out_c, port_out_fault); end
        tests++; if (port_err_count !== 4'd0 || port_alarm !== 1'b0) begin fails++; $display("FAIL basic_status got=%0d/%b exp=0/0", port_err_count, port_alarm); end
        step();
        tests++; if (port_out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got=%b exp=0", port_out_valid); end
    endtask

    task automatic test_backpressure();
        port_out_ready = 1'b0; port_flag_in = 1'b1;
        port_c_in = 6'h3f; port_in_valid = 1'b1;
        step();
        port_c_in = 6'h00;
        tests++; if (port_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got=%b exp=1", port_in_ready); end
        step();
        port_c_in = 6'h3f;
        tests++; if (port_in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got=%b exp=0", port_in_ready); end
        step();
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h3f) begin fails++; $display("FAIL bp_hold got=%b/%h exp=1/3f", port_out_valid, port_out_c); end
        port_in_valid = 1'b0; port_out_ready = 1'b1;
        step();
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h00) begin fails++; $display("FAIL bp_order got=%b/%h exp=1/00", port_out_valid, port_out_c); end
        tests++; if (port_in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_back got=%b exp=1", port_in_ready); end
        step();
        tests++; if (port_out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got=%b exp=0 (third word must not be accepted)", port_out_valid); end
    endtask

`ifdef FINI_ERR_COUNT_EN
    task automatic test_infect();
        port_out_ready = 1'b1;
        port_c_in = 6'b110111; port_flag_in = 1'b1; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h00 || port_out_fault !== 1'b1) begin fails++; $display("FAIL infect1_out got=%b/%h/%b exp=1/00/1", port_out_valid, port_out_c, port_out_fault); end
        tests++; if (port_err_count !== 4'd1 || port_alarm !== 1'b0) begin fails++; $display("FAIL infect1_count got=%0d/%b exp=1/0", port_err_count, port_alarm); end
        step();
        port_c_in = 6'h3f; port_flag_in = 1'b0; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0; port_flag_in = 1'b1;
        tests++; if (port_out_c !== 6'h00 || port_out_fault !== 1'b1) begin fails++; $display("FAIL infect2_out got=%h/%b exp=00/1", port_out_c, port_out_fault); end
        tests++; if (port_err_count !== 4'd2) begin fails++; $display("FAIL infect2_count got=%0d exp=2", port_err_count); end
        step();
    endtask

    task automatic test_lock();
        port_out_ready = 1'b0;
        port_c_in = 6'h3f; port_flag_in = 1'b1; port_in_valid = 1'b1;
        step();
        port_c_in = 6'h00; port_flag_in = 1'b0;
        step();
        tests++; if (port_alarm !== 1'b1 || port_out_valid !== 1'b0) begin fails++; $display("FAIL lock_state got=%b/%b exp=1/0", port_alarm, port_out_valid); end
        tests++; if (port_err_count !== 4'd3 || port_in_ready !== 1'b1) begin fails++; $display("FAIL lock_count got=%0d/%b exp=3/1", port_err_count, port_in_ready); end
        port_c_in = 6'b010101;
        step();
        step();
        port_in_valid = 1'b0;
        tests++; if (port_err_count !== 4'd3 || port_alarm !== 1'b1 || port_out_valid !== 1'b0) begin fails++; $display("FAIL lock_frozen got=%0d/%b/%b exp=3/1/0", port_err_count, port_alarm, port_out_valid); end
    endtask
`else
    task automatic test_lock();
        port_out_ready = 1'b0;
        port_c_in = 6'h3f; port_flag_in = 1'b1; port_in_valid = 1'b1;
        step();
        port_c_in = 6'b011111;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_alarm !== 1'b1 || port_out_valid !== 1'b0) begin fails++; $display("FAIL lock_direct got=%b/%b exp=1/0", port_alarm, port_out_valid); end
        tests++; if (port_err_count !== 4'd0 || port_in_ready !== 1'b1) begin fails++; $display("FAIL lock_direct_count got=%0d/%b exp=0/1", port_err_count, port_in_ready); end
        port_c_in = 6'h3f; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_out_valid !== 1'b0 || port_alarm !== 1'b1) begin fails++; $display("FAIL lock_sink got=%b/%b exp=0/1", port_out_valid, port_alarm); end
    endtask
`endif

    task automatic test_reset_in_lock();
        port_rst = 1'b1; port_in_valid = 1'b0;
        step();
        tests++; if (port_alarm !== 1'b0 || port_err_count !== 4'd0 || port_out_valid !== 1'b0) begin fails++; $display("FAIL rlock_clear got=%b/%0d/%b exp=0/0/0", port_alarm, port_err_count, port_out_valid); end
        tests++; if (port_in_ready !== 1'b0) begin fails++; $display("FAIL rlock_ready got=%b exp=0", port_in_ready); end
        port_rst = 1'b0; port_out_ready = 1'b1;
        port_c_in = 6'h00; port_flag_in = 1'b1; port_in_valid = 1'b1;
        step();
        port_in_valid = 1'b0;
        tests++; if (port_out_valid !== 1'b1 || port_out_c !== 6'h00 || port_out_fault !== 1'b0) begin fails++; $display("FAIL rlock_resume got=%b/%h/%b exp=1/00/0", port_out_valid, port_out_c, port_out_fault); end
        step();
        tests++; if (port_out_valid !== 1'b0 || port_alarm !== 1'b0) begin fails++; $display("FAIL rlock_drain got=%b/%b exp=0/0", port_out_valid, port_alarm); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
`ifdef FINI_ERR_COUNT_EN
        test_infect();
`endif
        test_lock();
        test_reset_in_lock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
